mq_pop_sched_1k1l: RTL

Pop scheduler and read-return buffer that sits directly downstream of the 1k1l multi-queue (NUMQUEU logical queues sharing one cell pool). It tracks per-queue occupancy by watching the queue's push port and issues round-robin pops to non-empty queues. Issue is credit-limited so that every returning word fits in a local output FIFO. Returned words (po_dvld/po_dout, fixed DELAY latency) are tagged with their queue id and presented on a valid/ready output.

---
 rtl/mq_pop_sched_1k1l.sv | 107 ++++++++++
 1 files changed

// File: rtl/mq_pop_sched_1k1l.sv
// mq_pop_sched_1k1l: credit-limited round-robin pop scheduler with tagged read-return FIFO
//   clk, rst (async, active-low)
//   ready             queue initialised; gates pop issue
//   push, pu_adr      observed queue push, used to track per-queue occupancy
//   pop, po_adr       registered pop request to the queue
//   po_dvld, po_dout  pop data returned DELAY cycles after pop
//   out_vld/out_rdy   valid/ready output carrying out_que (queue id) and out_data
//   err               sticky protocol error (queue overflow, unexpected/missing return, FIFO overflow)
module mq_pop_sched_1k1l #(
  parameter int NUMQUEU = 64,
  parameter int BITQUEU = 6,
  parameter int DEPTH   = 32,
  parameter int BITADDR = 5,
  parameter int WIDTH   = 8,
  parameter int DELAY   = 4,
  parameter int FIFODEP = 8,
  parameter int BITFIFO = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ready,
  input  logic               push,
  input  logic [BITQUEU-1:0] pu_adr,
  output logic               pop,
  output logic [BITQUEU-1:0] po_adr,
  input  logic               po_dvld,
  input  logic [WIDTH-1:0]   po_dout,
  output logic               out_vld,
  output logic [BITQUEU-1:0] out_que,
  output logic [WIDTH-1:0]   out_data,
  input  logic               out_rdy,
  output logic               err
);
  logic [BITADDR:0]         cnt [NUMQUEU];
  logic [BITQUEU-1:0]       rr_ptr, win;
  logic [BITQUEU:0]         sum;
  logic                     found, issue;
  logic [BITFIFO:0]         inflight, fifo_cnt;
  logic [DELAY-1:0]         exp_vld;
  logic [BITQUEU-1:0]       exp_id [DELAY];
  logic [BITQUEU+WIDTH-1:0] mem [FIFODEP];
  logic [BITFIFO-1:0]       wptr, rptr;
  logic                     tail_vld, wr_req, full, wr, rd, q_ovf;
  // Scan from the highest offset down so the last hit is the queue closest to rr_ptr.
  always_comb begin
    found = 1'b0;
    win = rr_ptr;
    sum = '0;
    for (int i = NUMQUEU - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + (BITQUEU+1)'(i);
      sum = sum >= (BITQUEU+1)'(NUMQUEU) ? sum - (BITQUEU+1)'(NUMQUEU) : sum;
      if (cnt[sum[BITQUEU-1:0]] != '0) begin
        found = 1'b1;
        win = sum[BITQUEU-1:0];
      end
    end
  end
  // Credits cover every word that is either buffered or still on its way back.
  assign issue    = ready && found &&
                    ({1'b0, fifo_cnt} + {1'b0, inflight} < (BITFIFO+2)'(FIFODEP));
  assign tail_vld = exp_vld[DELAY-1];
  assign wr_req   = po_dvld && tail_vld;
  assign full     = fifo_cnt == (BITFIFO+1)'(FIFODEP);
  assign wr       = wr_req && !full;
  assign rd       = out_vld && out_rdy;
  assign out_vld  = fifo_cnt != '0;
  assign {out_que, out_data} = mem[rptr];
  // A push to a full queue is only an error if it is not paired with a pop of that queue.
  assign q_ovf    = push && cnt[pu_adr] == (BITADDR+1)'(DEPTH) && !(issue && win == pu_adr);
  for (genvar g = 0; g < NUMQUEU; g++) begin : g_cnt
    logic inc, dec;
    assign inc = push && pu_adr == BITQUEU'(g);
    assign dec = issue && win == BITQUEU'(g);
    always_ff @(posedge clk or negedge rst)
      if (!rst) cnt[g] <= '0;
      else cnt[g] <= (dec && !inc) ? cnt[g] - 1'b1 :
                     (inc && !dec && cnt[g] != (BITADDR+1)'(DEPTH)) ? cnt[g] + 1'b1 : cnt[g];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pop      <= 1'b0;
      po_adr   <= '0;
      rr_ptr   <= '0;
      inflight <= '0;
      exp_vld  <= '0;
      for (int i = 0; i < DELAY; i++) exp_id[i] <= '0;
      for (int i = 0; i < FIFODEP; i++) mem[i] <= '0;
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= '0;
      err      <= 1'b0;
    end else begin
      pop      <= issue;
      po_adr   <= issue ? win : po_adr;
      rr_ptr   <= !issue ? rr_ptr : win == BITQUEU'(NUMQUEU - 1) ? '0 : win + 1'b1;
      inflight <= (issue && !tail_vld) ? inflight + 1'b1 :
                  (!issue && tail_vld) ? inflight - 1'b1 : inflight;
      exp_vld  <= {exp_vld[DELAY-2:0], pop};
      for (int i = DELAY - 1; i > 0; i--) exp_id[i] <= exp_id[i-1];
      exp_id[0] <= po_adr;
      if (wr) mem[wptr] <= {exp_id[DELAY-1], po_dout};
      wptr     <= wr ? wptr + 1'b1 : wptr;
      rptr     <= rd ? rptr + 1'b1 : rptr;
      fifo_cnt <= (wr && !rd) ? fifo_cnt + 1'b1 : (!wr && rd) ? fifo_cnt - 1'b1 : fifo_cnt;
      err      <= err || q_ovf || (po_dvld != tail_vld) || (wr_req && full);
    end
endmodule
